// File: rtl/data_memory_responder_pkg.sv
// Shared encodings and address-region decode for the MEM-stage data memory responder.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] OFF_LED  = 4'h0;
    localparam logic [3:0] OFF_CNT  = 4'h4;
    localparam logic [3:0] OFF_CMP  = 4'h8;
    localparam logic [3:0] OFF_STAT = 4'hC;

    typedef enum logic [1:0] {
        REGION_RAM,
        REGION_MMIO,
        REGION_NONE
    } region_t;

    function automatic region_t decode_region(input logic [31:0] addr,
                                              input logic [31:0] ram_bytes,
                                              input logic [31:0] mmio_base);
        if (addr < ram_bytes) begin
            return REGION_RAM;
        end
        if (addr[31:4] == mmio_base[31:4]) begin
            return REGION_MMIO;
        end
        return REGION_NONE;
    endfunction

endpackage

// File: rtl/data_memory_responder_if.sv
// Core MEM-stage bus: the core drives address/data/enable/size, the responder returns load data and error.
interface data_memory_responder_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] ram_address;
    logic [WIDTH-1:0] ram_w_data;
    logic             read_write_ram_en;
    logic [2:0]       funct3_m;
    logic [WIDTH-1:0] ram_r_data;
    logic             access_err;

    modport master (
        output ram_address, ram_w_data, read_write_ram_en, funct3_m,
        input  ram_r_data, access_err
    );

    modport slave (
        input  ram_address, ram_w_data, read_write_ram_en, funct3_m,
        output ram_r_data, access_err
    );
endinterface

// File: rtl/data_memory_responder_mmio_timer.sv
// Free-running counter with a compare register and a sticky match flag (write-1-to-clear).
import dmem_pkg::*;

module mmio_timer (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmp_we,
    input  logic [31:0] cmp_wdata,
    input  logic        stat_clr,
    output logic [31:0] counter,
    output logic [31:0] compare,
    output logic        timer_irq
);

    logic status_match;

    // A match on the same edge as a clear keeps the flag set so no event is lost.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            counter      <= '0;
            compare      <= 32'hFFFF_FFFF;
            status_match <= 1'b0;
        end else begin
            counter <= counter + 32'd1;
            if (cmp_we) begin
                compare <= cmp_wdata;
            end
            if (counter == compare) begin
                status_match <= 1'b1;
            end else if (stat_clr) begin
                status_match <= 1'b0;
            end
        end
    end

    assign timer_irq = status_match;

endmodule

// File: rtl/data_memory_responder.sv
// Word-organised data RAM plus LED/timer MMIO window; combinational loads, byte-enabled stores.
import dmem_pkg::*;

module data_memory_responder #(
    parameter int              WIDTH       = 32,
    parameter int              DEPTH_WORDS = 1024,
    parameter logic [31:0]     MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic                   clock,
    input  logic                   reset,
    data_memory_responder_if.slave bus,
    output logic [WIDTH-1:0]       led_out,
    output logic                   timer_irq
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

    logic [31:0] mem [DEPTH_WORDS];

    region_t     region;
    logic [AW-1:0] word_idx;
    logic [3:0]  offset;
    logic        size_ok;
    logic        aligned;
    logic        legal;
    logic        ram_we;
    logic        mmio_we;
    logic [3:0]  byte_en;
    logic [31:0] lane_data;
    logic [31:0] raw_word;
    logic [31:0] shifted;
    logic [31:0] load_data;
    logic [31:0] counter;
    logic [31:0] compare;

    assign region   = decode_region(bus.ram_address, RAM_BYTES, MMIO_BASE);
    assign word_idx = bus.ram_address[AW+1:2];
    assign offset   = bus.ram_address[3:0];

    always_comb begin
        size_ok = 1'b1;
        aligned = 1'b1;
        case (bus.funct3_m)
            F3_B, F3_BU: aligned = 1'b1;
            F3_H, F3_HU: aligned = ~bus.ram_address[0];
            F3_W:        aligned = (bus.ram_address[1:0] == 2'b00);
            default:     size_ok = 1'b0;
        endcase
    end

    // MMIO registers are word-only, so any narrower access there is an error.
    assign legal = size_ok && aligned && (region != REGION_NONE) &&
                   !((region == REGION_MMIO) && (bus.funct3_m != F3_W));

    assign bus.access_err = ~legal;
    assign ram_we  = bus.read_write_ram_en && legal && (region == REGION_RAM);
    assign mmio_we = bus.read_write_ram_en && legal && (region == REGION_MMIO);

    always_comb begin
        byte_en   = 4'b0000;
        lane_data = bus.ram_w_data;
        case (bus.funct3_m)
            F3_B: begin
                byte_en   = 4'b0001 << bus.ram_address[1:0];
                lane_data = {4{bus.ram_w_data[7:0]}};
            end
            F3_H: begin
                byte_en   = bus.ram_address[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{bus.ram_w_data[15:0]}};
            end
            F3_W:    byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (ram_we && byte_en[i]) begin
                mem[word_idx][8*i +: 8] <= lane_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            led_out <= '0;
        end else if (mmio_we && (offset == OFF_LED)) begin
            led_out <= bus.ram_w_data;
        end
    end

    mmio_timer u_timer (
        .clock     (clock),
        .reset     (reset),
        .cmp_we    (mmio_we && (offset == OFF_CMP)),
        .cmp_wdata (bus.ram_w_data),
        .stat_clr  (mmio_we && (offset == OFF_STAT) && bus.ram_w_data[0]),
        .counter   (counter),
        .compare   (compare),
        .timer_irq (timer_irq)
    );

    always_comb begin
        raw_word = '0;
        if (region == REGION_RAM) begin
            raw_word = mem[word_idx];
        end else if (region == REGION_MMIO) begin
            case (offset)
                OFF_LED:  raw_word = led_out;
                OFF_CNT:  raw_word = counter;
                OFF_CMP:  raw_word = compare;
                OFF_STAT: raw_word = {31'b0, timer_irq};
                default:  raw_word = '0;
            endcase
        end
    end

    // Aligning the selected lane down to bit 0 lets one extender serve all sizes.
    assign shifted = raw_word >> {bus.ram_address[1:0], 3'b000};

    always_comb begin
        load_data = '0;
        case (bus.funct3_m)
            F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    load_data = raw_word;
            F3_BU:   load_data = {24'b0, shifted[7:0]};
            F3_HU:   load_data = {16'b0, shifted[15:0]};
            default: load_data = '0;
        endcase
    end

    assign bus.ram_r_data = legal ? load_data : '0;

endmodule
